// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller wrapped around a single full_adder cell.
// Operands and carry-in are latched on an accepted start, then one bit pair per
// cycle (LSB first) is streamed through the cell while the carry lives in a flop.
// The sum is collected in a right-shifting result register, and done pulses for
// one cycle when sum/cout are valid.
// Optional feature: define SERIAL_ADD_OVF_EN to add the o_ovf signed-overflow output.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_srA;
    logic [WIDTH-1:0] r_srB;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_lastBit;
    logic             w_faSum;
    logic             w_faCarry;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_carryIntoMsb;
`endif

    // Start is honoured only when no add is in flight (IDLE or the DONE cycle).
    assign w_accept  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_lastBit = (r_cnt == LAST_BIT);

    full_adder u_fa (
        .i_a     (r_srA[0]),
        .i_b     (r_srB[0]),
        .i_c     (r_carry),
        .o_sum   (w_faSum),
        .o_carry (w_faCarry)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: DONE lasts exactly one cycle, chaining straight into SHIFT on a new start.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nextState = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_lastBit) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_nextState = S_SHIFT;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on an accepted start, otherwise shift one bit per SHIFT cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_srA   <= '0;
            r_srB   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_srA   <= i_a;
            r_srB   <= i_b;
            r_sum   <= '0;
            r_carry <= i_cin;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_srA   <= {1'b0, r_srA[WIDTH-1:1]};
            r_srB   <= {1'b0, r_srB[WIDTH-1:1]};
            r_sum   <= {w_faSum, r_sum[WIDTH-1:1]};
            r_carry <= w_faCarry;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_lastBit) begin
                r_cout <= w_faCarry;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Capture the carry entering the MSB; with the held carry-out it gives signed overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_carryIntoMsb <= 1'b0;
        end else if (w_accept) begin
            r_carryIntoMsb <= 1'b0;
        end else if ((r_state == S_SHIFT) && w_lastBit) begin
            r_carryIntoMsb <= r_carry;
        end
    end

    assign o_ovf = r_carryIntoMsb ^ r_cout;
`endif

    assign o_busy = (r_state == S_SHIFT);
    assign o_done = (r_state == S_DONE);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): a vector table, randomized
// operations against an arithmetic reference model, and hand-written sequences
// for reset-in-flight and back-to-back starts. Build with SERIAL_ADD_OVF_EN to
// also check o_ovf.

module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         iStart;
   logic [W-1:0] iA;
   logic [W-1:0] iB;
   logic         iCin;
   logic         oBusy;
   logic         oDone;
   logic [W-1:0] oSum;
   logic         oCout;
`ifdef SERIAL_ADD_OVF_EN
   logic         oOvf;
`endif

   int totalChecks = 0;
   int badChecks   = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] expSum;
      logic         expCout;
      logic         expOvf;
   } vector_t;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (iStart),
      .i_a     (iA),
      .i_b     (iB),
      .i_cin   (iCin),
      .o_busy  (oBusy),
      .o_done  (oDone),
      .o_sum   (oSum),
      .o_cout  (oCout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .o_ovf   (oOvf)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: bump the totals and report any disagreement.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   // Reference: plain integer addition; signed overflow from the signed-range test.
   function automatic logic [W+1:0] refAdd(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      int unsigned full;
      int          sgn;
      logic        ovf;
      full = int'(a) + int'(b) + int'(cin);
      sgn  = int'($signed(a)) + int'($signed(b)) + int'(cin);
      ovf  = (sgn > 127) || (sgn < -128);
      refAdd = {ovf, full[W], full[W-1:0]};
   endfunction

   // Launch one add and watch it to completion; optionally scribble on inputs during SHIFT.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input bit disturb, output int doneAt, output int busyCnt);
      @(negedge clk);
      iA = a;
      iB = b;
      iCin = cin;
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      doneAt = 0;
      busyCnt = 0;
      for (int k = 1; k <= 30 && doneAt == 0; k++) begin
         if (k > 1) @(negedge clk);
         if (oBusy) busyCnt++;
         if (oDone) begin
            doneAt = k;
         end else if (disturb) begin
            iA = W'($urandom);
            iB = W'($urandom);
            iCin = 1'($urandom);
            iStart = 1'($urandom);
         end
      end
      iStart = 1'b0;
   endtask

   // Run one operation and compare result, latency, busy length and hold-after-done.
   task automatic runAndCheck(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input bit disturb);
      int doneAt;
      int busyCnt;
      logic [W+1:0] exp;
      exp = refAdd(a, b, cin);
      applyStimulus(a, b, cin, disturb, doneAt, busyCnt);
      checkOutput({tag, " latency"}, doneAt, W + 1);
      checkOutput({tag, " busyCycles"}, busyCnt, W);
      checkOutput({tag, " sum"}, oSum, exp[W-1:0]);
      checkOutput({tag, " cout"}, oCout, exp[W]);
`ifdef SERIAL_ADD_OVF_EN
      checkOutput({tag, " ovf"}, oOvf, exp[W+1]);
`endif
      @(negedge clk);
      checkOutput({tag, " donePulse"}, oDone, 0);
      checkOutput({tag, " sumHeld"}, oSum, exp[W-1:0]);
   endtask

   vector_t vectors[7];

   initial begin
      int doneAt;
      int busyCnt;
      bit sawDone;

      vectors[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, expSum: 8'h00, expCout: 1'b0, expOvf: 1'b0};
      vectors[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, expSum: 8'h00, expCout: 1'b1, expOvf: 1'b0};
      vectors[2] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, expSum: 8'h00, expCout: 1'b1, expOvf: 1'b0};
      vectors[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, expSum: 8'h80, expCout: 1'b0, expOvf: 1'b1};
      vectors[4] = '{a: 8'h3C, b: 8'h03, cin: 1'b0, expSum: 8'h3F, expCout: 1'b0, expOvf: 1'b0};
      vectors[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, expSum: 8'h00, expCout: 1'b1, expOvf: 1'b1};
      vectors[6] = '{a: 8'h12, b: 8'h34, cin: 1'b1, expSum: 8'h47, expCout: 1'b0, expOvf: 1'b0};

      iStart = 1'b0;
      iA = '0;
      iB = '0;
      iCin = 1'b0;
      rst = 1'b1;
      #12;
      checkOutput("reset busy", oBusy, 0);
      checkOutput("reset done", oDone, 0);
      checkOutput("reset sum", oSum, 0);
      checkOutput("reset cout", oCout, 0);
`ifdef SERIAL_ADD_OVF_EN
      checkOutput("reset ovf", oOvf, 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors with hand-computed expectations.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vectors[i].a, vectors[i].b, vectors[i].cin, 1'b0, doneAt, busyCnt);
         checkOutput($sformatf("vec%0d latency", i), doneAt, W + 1);
         checkOutput($sformatf("vec%0d busyCycles", i), busyCnt, W);
         checkOutput($sformatf("vec%0d sum", i), oSum, vectors[i].expSum);
         checkOutput($sformatf("vec%0d cout", i), oCout, vectors[i].expCout);
`ifdef SERIAL_ADD_OVF_EN
         checkOutput($sformatf("vec%0d ovf", i), oOvf, vectors[i].expOvf);
`endif
      end

      // Randomized operations, half of them with inputs and start churning during SHIFT.
      for (int i = 0; i < 30; i++) begin
         runAndCheck($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom), i[0]);
      end

      // Async reset four shift edges into an add: outputs clear at once, no done follows.
      @(negedge clk);
      iA = 8'h3C;
      iB = 8'h03;
      iCin = 1'b0;
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("midReset busyBefore", oBusy, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midReset busy", oBusy, 0);
      checkOutput("midReset done", oDone, 0);
      checkOutput("midReset sum", oSum, 0);
      checkOutput("midReset cout", oCout, 0);
      @(negedge clk);
      rst = 1'b0;
      sawDone = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (oDone || oBusy) sawDone = 1'b1;
      end
      checkOutput("midReset noDone", sawDone, 0);
      runAndCheck("afterReset", 8'h3C, 8'h03, 1'b0, 1'b0);

      // Start held high: back-to-back adds, operand change during SHIFT is ignored.
      @(negedge clk);
      iA = 8'h0F;
      iB = 8'h01;
      iCin = 1'b0;
      iStart = 1'b1;
      @(negedge clk);
      iA = 8'h10;
      iB = 8'h10;
      repeat (W) @(negedge clk);
      checkOutput("b2b first done", oDone, 1);
      checkOutput("b2b first sum", oSum, 8'h10);
      @(negedge clk);
      checkOutput("b2b gap busy", oBusy, 1);
      checkOutput("b2b gap done", oDone, 0);
      repeat (W) @(negedge clk);
      checkOutput("b2b second done", oDone, 1);
      checkOutput("b2b second sum", oSum, 8'h20);
      iStart = 1'b0;
      @(negedge clk);
      checkOutput("b2b idle done", oDone, 0);
      checkOutput("b2b idle busy", oBusy, 0);
      checkOutput("b2b held sum", oSum, 8'h20);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
